// File: rtl/sprite_pkg.sv
// Shared sprite types, widths and the lowest-index priority encoder.
`include "config.svh"

package sprite_pkg;

  localparam int unsigned XPosW         = `X_POS_W;
  localparam int unsigned YPosW         = `Y_POS_W;
  localparam int unsigned RgbW          = `VGA_RGB_W;
  localparam int unsigned SizeWMax      = 16;
  localparam int unsigned N_SPRITES_MAX = 8;
  localparam int unsigned IdxW          = $clog2(N_SPRITES_MAX);

  typedef struct packed {
    logic [XPosW-1:0]    x;
    logic [YPosW-1:0]    y;
    logic [SizeWMax-1:0] w;
    logic [SizeWMax-1:0] h;
    logic [RgbW-1:0]     rgb;
    logic                en;
  } sprite_t;

  typedef struct packed {
    logic [IdxW-1:0] idx;
    logic            found;
  } prio_t;

  // Scan high to low so the lowest set bit is the last one written.
  function automatic prio_t prio_encode(input logic [N_SPRITES_MAX-1:0] vec);
    prio_t res;
    res = '0;
    for (int i = N_SPRITES_MAX - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.idx   = IdxW'(i);
        res.found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/config.svh
// Global display widths shared by the VGA path.
`ifndef CONFIG_SVH
`define CONFIG_SVH
`define X_POS_W 10
`define Y_POS_W 10
`define VGA_RGB_W 12
`endif

// File: rtl/sprite_hit.sv
// One sprite: frame-shadowed attributes and a registered coverage bit for the current pixel.
`include "config.svh"

module sprite_hit
  import sprite_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             frame_start_i,
  input  sprite_t          sprite_i,
  input  logic             pixel_valid_i,
  input  logic [XPosW-1:0] pixel_x_i,
  input  logic [YPosW-1:0] pixel_y_i,
  output logic             hit_o,
  output logic [RgbW-1:0]  rgb_o
);

  localparam int unsigned XSumW = ((XPosW > SizeWMax) ? XPosW : SizeWMax) + 1;
  localparam int unsigned YSumW = ((YPosW > SizeWMax) ? YPosW : SizeWMax) + 1;

  sprite_t          shadow_d, shadow_q;
  logic             hit_d, hit_q;
  logic [XSumW-1:0] x_end;
  logic [YSumW-1:0] y_end;
  logic             in_x, in_y;

  always_comb begin
    shadow_d = frame_start_i ? sprite_i : shadow_q;
    // Extra sum bit keeps sprites near the right/bottom edge from wrapping to 0.
    x_end = XSumW'(shadow_q.x) + XSumW'(shadow_q.w);
    y_end = YSumW'(shadow_q.y) + YSumW'(shadow_q.h);
    in_x  = (pixel_x_i >= shadow_q.x) && (XSumW'(pixel_x_i) < x_end);
    in_y  = (pixel_y_i >= shadow_q.y) && (YSumW'(pixel_y_i) < y_end);
    hit_d = pixel_valid_i & shadow_q.en & in_x & in_y;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      hit_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      hit_q    <= hit_d;
    end
  end

  assign hit_o = hit_q;
  assign rgb_o = shadow_q.rgb;

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: 2-stage hit/priority pipeline plus per-frame overlap flags.
`include "config.svh"

module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int unsigned N_SPRITES = 3,
  parameter int unsigned SIZE_W    = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              frame_start_i,
  input  logic                              pixel_valid_i,
  input  logic [`X_POS_W-1:0]               pixel_x_i,
  input  logic [`Y_POS_W-1:0]               pixel_y_i,
  input  logic [N_SPRITES*`X_POS_W-1:0]     pos_x_i,
  input  logic [N_SPRITES*`Y_POS_W-1:0]     pos_y_i,
  input  logic [N_SPRITES*SIZE_W-1:0]       size_w_i,
  input  logic [N_SPRITES*SIZE_W-1:0]       size_h_i,
  input  logic [N_SPRITES*`VGA_RGB_W-1:0]   color_i,
  input  logic [N_SPRITES-1:0]              enable_i,
  input  logic [`VGA_RGB_W-1:0]             bg_rgb_i,
  output logic [`VGA_RGB_W-1:0]             vga_rgb_o,
  output logic                              pixel_valid_o,
  output logic                              on_sprite_o,
  output logic [$clog2(N_SPRITES)-1:0]      hit_id_o,
  output logic [N_SPRITES-1:0]              collide_o,
  output logic                              collide_valid_o
);

  localparam int unsigned IdW = $clog2(N_SPRITES);

  logic [N_SPRITES-1:0] hit_vec;
  logic [RgbW-1:0]      shadow_rgb [N_SPRITES];

  for (genvar k = 0; k < N_SPRITES; k++) begin : g_sprite
    sprite_t spr;
    assign spr = '{
      x:   pos_x_i[k*XPosW +: XPosW],
      y:   pos_y_i[k*YPosW +: YPosW],
      w:   SizeWMax'(size_w_i[k*SIZE_W +: SIZE_W]),
      h:   SizeWMax'(size_h_i[k*SIZE_W +: SIZE_W]),
      rgb: color_i[k*RgbW +: RgbW],
      en:  enable_i[k]
    };

    sprite_hit u_hit (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .frame_start_i (frame_start_i),
      .sprite_i      (spr),
      .pixel_valid_i (pixel_valid_i),
      .pixel_x_i     (pixel_x_i),
      .pixel_y_i     (pixel_y_i),
      .hit_o         (hit_vec[k]),
      .rgb_o         (shadow_rgb[k])
    );
  end

  logic                 valid1_d, valid1_q;
  logic [RgbW-1:0]      bg1_d, bg1_q;
  logic [RgbW-1:0]      rgb_d, rgb_q;
  logic                 valid2_d, valid2_q;
  logic                 on_d, on_q;
  logic [IdW-1:0]       id_d, id_q;
  logic [N_SPRITES-1:0] acc_d, acc_q;
  logic [N_SPRITES-1:0] collide_d, collide_q;
  logic                 cvalid_d, cvalid_q;
  logic [N_SPRITES-1:0] contrib;
  prio_t                pe;
  logic [IdW-1:0]       win_id;

  always_comb begin
    valid1_d = pixel_valid_i;
    bg1_d    = bg_rgb_i;

    pe       = prio_encode(N_SPRITES_MAX'(hit_vec));
    win_id   = IdW'(pe.idx);
    valid2_d = valid1_q;
    rgb_d    = '0;
    on_d     = 1'b0;
    id_d     = '0;
    if (valid1_q) begin
      rgb_d = pe.found ? shadow_rgb[win_id] : bg1_q;
      on_d  = pe.found;
      id_d  = pe.found ? win_id : '0;
    end

    // Two or more bits set <=> clearing the lowest set bit leaves something.
    contrib   = (|(hit_vec & (hit_vec - N_SPRITES'(1)))) ? hit_vec : '0;
    acc_d     = acc_q | contrib;
    collide_d = collide_q;
    cvalid_d  = 1'b0;
    if (frame_start_i) begin
      collide_d = acc_q | contrib;
      cvalid_d  = 1'b1;
      acc_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid1_q  <= 1'b0;
      bg1_q     <= '0;
      rgb_q     <= '0;
      valid2_q  <= 1'b0;
      on_q      <= 1'b0;
      id_q      <= '0;
      acc_q     <= '0;
      collide_q <= '0;
      cvalid_q  <= 1'b0;
    end else begin
      valid1_q  <= valid1_d;
      bg1_q     <= bg1_d;
      rgb_q     <= rgb_d;
      valid2_q  <= valid2_d;
      on_q      <= on_d;
      id_q      <= id_d;
      acc_q     <= acc_d;
      collide_q <= collide_d;
      cvalid_q  <= cvalid_d;
    end
  end

  assign vga_rgb_o       = rgb_q;
  assign pixel_valid_o   = valid2_q;
  assign on_sprite_o     = on_q;
  assign hit_id_o        = id_q;
  assign collide_o       = collide_q;
  assign collide_valid_o = cvalid_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: coverage, priority, shadowing, edge, collision, reset.
module tb_sprite_compositor;
  import sprite_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned SW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 frame_start;
  logic                 pixel_valid;
  logic [XPosW-1:0]     pixel_x;
  logic [YPosW-1:0]     pixel_y;
  logic [N*XPosW-1:0]   pos_x;
  logic [N*YPosW-1:0]   pos_y;
  logic [N*SW-1:0]      size_w;
  logic [N*SW-1:0]      size_h;
  logic [N*RgbW-1:0]    color;
  logic [N-1:0]         enable;
  logic [RgbW-1:0]      bg_rgb;
  logic [RgbW-1:0]      vga_rgb;
  logic                 pix_valid_out;
  logic                 on_sprite;
  logic [1:0]           hit_id;
  logic [N-1:0]         collide;
  logic                 collide_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [RgbW-1:0] Bg = 12'h123;

  always #5 clk = ~clk;

  sprite_compositor #(
    .N_SPRITES (N),
    .SIZE_W    (SW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .frame_start_i   (frame_start),
    .pixel_valid_i   (pixel_valid),
    .pixel_x_i       (pixel_x),
    .pixel_y_i       (pixel_y),
    .pos_x_i         (pos_x),
    .pos_y_i         (pos_y),
    .size_w_i        (size_w),
    .size_h_i        (size_h),
    .color_i         (color),
    .enable_i        (enable),
    .bg_rgb_i        (bg_rgb),
    .vga_rgb_o       (vga_rgb),
    .pixel_valid_o   (pix_valid_out),
    .on_sprite_o     (on_sprite),
    .hit_id_o        (hit_id),
    .collide_o       (collide),
    .collide_valid_o (collide_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_sprite(input int k, input int x, input int y, input int w, input int h,
                            input logic [RgbW-1:0] rgb);
    pos_x[k*XPosW +: XPosW] = XPosW'(x);
    pos_y[k*YPosW +: YPosW] = YPosW'(y);
    size_w[k*SW +: SW]      = SW'(w);
    size_h[k*SW +: SW]      = SW'(h);
    color[k*RgbW +: RgbW]   = rgb;
  endtask

  // One pixel in, bubble behind it, result two edges later.
  task automatic check_px(input string tag, input int x, input int y,
                          input logic [RgbW-1:0] exp_rgb, input logic exp_on,
                          input logic [1:0] exp_id);
    pixel_valid = 1'b1;
    pixel_x     = XPosW'(x);
    pixel_y     = YPosW'(y);
    step();
    pixel_valid = 1'b0;
    step();
    chk({tag, ".valid"}, 32'(pix_valid_out), 32'd1);
    chk({tag, ".rgb"}, 32'(vga_rgb), 32'(exp_rgb));
    chk({tag, ".on"}, 32'(on_sprite), 32'(exp_on));
    chk({tag, ".id"}, 32'(hit_id), 32'(exp_id));
  endtask

  task automatic frame_pulse(input string tag, input logic [N-1:0] exp_collide);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk({tag, ".cvalid"}, 32'(collide_valid), 32'd1);
    chk({tag, ".collide"}, 32'(collide), 32'(exp_collide));
    step();
    chk({tag, ".cvalid_drop"}, 32'(collide_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_x     = '0;
    pixel_y     = '0;
    pos_x       = '0;
    pos_y       = '0;
    size_w      = '0;
    size_h      = '0;
    color       = '0;
    enable      = '0;
    bg_rgb      = Bg;
    step();
    step();
    rst = 1'b0;
    chk("rst.rgb", 32'(vga_rgb), 32'd0);
    chk("rst.valid", 32'(pix_valid_out), 32'd0);
    chk("rst.on", 32'(on_sprite), 32'd0);
    chk("rst.id", 32'(hit_id), 32'd0);
    chk("rst.collide", 32'(collide), 32'd0);
    chk("rst.cvalid", 32'(collide_valid), 32'd0);

    // Programmed but not yet shadowed: nothing draws.
    set_sprite(0, 10, 10, 4, 4, 12'h00A);
    enable = 3'b001;
    check_px("noframe", 11, 11, Bg, 1'b0, 2'd0);

    frame_pulse("f1", 3'b000);
    check_px("s0.tl", 10, 10, 12'h00A, 1'b1, 2'd0);
    check_px("s0.br", 13, 13, 12'h00A, 1'b1, 2'd0);
    check_px("s0.mid", 12, 11, 12'h00A, 1'b1, 2'd0);
    check_px("s0.left", 9, 10, Bg, 1'b0, 2'd0);
    check_px("s0.right", 14, 10, Bg, 1'b0, 2'd0);
    check_px("s0.below", 10, 14, Bg, 1'b0, 2'd0);
    step();
    chk("idle.valid", 32'(pix_valid_out), 32'd0);
    chk("idle.rgb", 32'(vga_rgb), 32'd0);

    // Overlap: sprite 0 at (20,20), sprite 1 at (22,22), both 4x4.
    set_sprite(0, 20, 20, 4, 4, 12'h00A);
    set_sprite(1, 22, 22, 4, 4, 12'h00B);
    enable = 3'b011;
    frame_pulse("f2", 3'b000);
    check_px("ov.s0only", 21, 21, 12'h00A, 1'b1, 2'd0);
    check_px("ov.s1only", 25, 25, 12'h00B, 1'b1, 2'd1);
    check_px("ov.both", 22, 22, 12'h00A, 1'b1, 2'd0);

    // Mid-frame move has no effect until the next frame.
    set_sprite(0, 100, 20, 4, 4, 12'h00A);
    check_px("mid.hold", 21, 21, 12'h00A, 1'b1, 2'd0);
    frame_pulse("f3", 3'b011);
    check_px("mid.old", 21, 21, Bg, 1'b0, 2'd0);
    check_px("mid.new", 100, 20, 12'h00A, 1'b1, 2'd0);

    // Reset while a hitting pixel is in flight.
    chk("prerst.collide", 32'(collide), 32'd3);
    pixel_valid = 1'b1;
    pixel_x     = XPosW'(101);
    pixel_y     = YPosW'(21);
    step();
    rst = 1'b1;
    step();
    rst         = 1'b0;
    pixel_valid = 1'b0;
    chk("midrst.valid", 32'(pix_valid_out), 32'd0);
    chk("midrst.rgb", 32'(vga_rgb), 32'd0);
    chk("midrst.collide", 32'(collide), 32'd0);
    chk("midrst.on", 32'(on_sprite), 32'd0);
    step();
    chk("midrst.stale", 32'(pix_valid_out), 32'd0);

    // Right-edge sprite plus a zero-width sprite; pixel coincident with frame_start.
    set_sprite(1, 0, 0, 0, 4, 12'h00B);
    set_sprite(2, 1021, 0, 8, 4, 12'h00C);
    enable      = 3'b110;
    frame_start = 1'b1;
    pixel_valid = 1'b1;
    pixel_x     = XPosW'(1021);
    pixel_y     = YPosW'(1);
    step();
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    chk("f4.cvalid", 32'(collide_valid), 32'd1);
    chk("f4.collide", 32'(collide), 32'd0);
    step();
    chk("fspx.rgb", 32'(vga_rgb), 32'(Bg));
    chk("fspx.on", 32'(on_sprite), 32'd0);
    check_px("edge.first", 1021, 1, 12'h00C, 1'b1, 2'd2);
    check_px("edge.last", 1023, 1, 12'h00C, 1'b1, 2'd2);
    check_px("edge.before", 1020, 1, Bg, 1'b0, 2'd0);
    check_px("edge.nowrap0", 0, 1, Bg, 1'b0, 2'd0);
    check_px("edge.nowrap5", 5, 1, Bg, 1'b0, 2'd0);
    check_px("edge.ybot", 1022, 3, 12'h00C, 1'b1, 2'd2);
    check_px("edge.ypast", 1022, 4, Bg, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
